// File: rtl/disp_pkg.sv
// Shared constants and state encoding for the display frame-fetch path.
package disp_pkg;
    localparam logic [2:0] AXI_ARSIZE_64   = 3'b011;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam int         BYTES_PER_PIXEL = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ADDR,
        ST_DATA
    } vram_state_t;
endpackage

// File: rtl/disp_vsync_sync.sv
// Brings the pixel-clock VSYNC_X into ACLK and flags its falling edge.
module disp_vsync_sync (
    input  logic ACLK,
    input  logic ARST,
    input  logic vsync_x,
    output logic vs_fall
);
    // [0],[1] synchronizer, [2] history; idle level of VSYNC_X is high
    logic [2:0] sync;

    always_ff @(posedge ACLK) begin
        if (ARST) sync <= 3'b111;
        else      sync <= {sync[1:0], vsync_x};
    end

    assign vs_fall = sync[2] & ~sync[1];
endmodule

// File: rtl/disp_vramctrl.sv
// Frame-fetch DMA: reads one frame per VSYNC from VRAM over AXI4 AR/R into the pixel FIFO.
// Optional FRAME_END pulse output is enabled with `define DISP_FRAME_END_EN.
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int H_PIXELS  = 640,
    parameter int V_LINES   = 480,
    parameter int BURST_LEN = 16
) (
    input  logic        ACLK,
    input  logic        ARST,
    input  logic        DSP_VSYNC_X,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [63:0] RDATA,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
    output logic        FIFO_WR,
    output logic [63:0] FIFO_WDATA,
`ifdef DISP_FRAME_END_EN
    output logic        FRAME_END,
`endif
    input  logic        FIFO_AFULL
);
    localparam int BEATS  = H_PIXELS * V_LINES * BYTES_PER_PIXEL / 8;
    localparam int NBURST = BEATS / BURST_LEN;
    localparam int STEP   = BURST_LEN * 8;

    localparam logic [15:0] NBURST_W = 16'(NBURST);
    localparam logic [31:0] STEP_W   = 32'(STEP);

    vram_state_t state, state_nxt;
    logic [15:0] count;
    logic [15:0] count_inc;
    logic        vs_fall;
    logic        beat;
    logic        last_acc;
    logic        frame_done;
    logic        start;
    logic        unused_addr_bits;

    assign unused_addr_bits = ^DISPADDR[6:0];

    disp_vsync_sync u_vsync (
        .ACLK    (ACLK),
        .ARST    (ARST),
        .vsync_x (DSP_VSYNC_X),
        .vs_fall (vs_fall)
    );

    assign ARLEN   = 8'(BURST_LEN - 1);
    assign ARSIZE  = AXI_ARSIZE_64;
    assign ARBURST = AXI_BURST_INCR;
    assign RREADY  = (state == ST_DATA);

    assign start      = (state == ST_IDLE) && vs_fall && DISPON;
    assign beat       = (state == ST_DATA) && RVALID;
    assign last_acc   = beat && RLAST;
    assign count_inc  = count + 16'd1;
    assign frame_done = (count_inc == NBURST_W);

    always_ff @(posedge ACLK) begin
        if (ARST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (start) state_nxt = ST_ADDR;
            ST_ADDR: if (ARVALID && ARREADY) state_nxt = ST_DATA;
            ST_DATA: begin
                // an open burst always runs to RLAST; DISPON only gates the next one
                if (last_acc) begin
                    if (frame_done || !DISPON) state_nxt = ST_IDLE;
                    else                       state_nxt = ST_ADDR;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARST) begin
            ARVALID    <= 1'b0;
            ARADDR     <= 32'h0;
            count      <= 16'h0;
            FIFO_WR    <= 1'b0;
            FIFO_WDATA <= 64'h0;
        end else begin
            FIFO_WR <= beat;
            if (beat) FIFO_WDATA <= RDATA;

            if (start) begin
                ARADDR <= {3'b000, DISPADDR[28:7], 7'b0};
                count  <= 16'h0;
            end

            // once raised, ARVALID waits for ARREADY regardless of FIFO_AFULL
            if (state == ST_ADDR) begin
                if (ARVALID && ARREADY) ARVALID <= 1'b0;
                else if (!FIFO_AFULL)   ARVALID <= 1'b1;
            end

            if (last_acc) begin
                count  <= count_inc;
                ARADDR <= ARADDR + STEP_W;
            end
        end
    end

`ifdef DISP_FRAME_END_EN
    always_ff @(posedge ACLK) begin
        if (ARST) FRAME_END <= 1'b0;
        else      FRAME_END <= last_acc && frame_done;
    end
`endif
endmodule

// File: tb/tb_disp_vramctrl.sv
// Scoreboard bench for disp_vramctrl with a small AXI read slave and memory model.
module tb_disp_vramctrl;
    localparam int H     = 64;
    localparam int V     = 16;
    localparam int BL    = 16;
    localparam int BEATS = H * V / 2;
    localparam int NB    = BEATS / BL;

    logic        ACLK = 1'b0;
    logic        ARST = 1'b1;
    logic        DSP_VSYNC_X = 1'b1;
    logic        DISPON = 1'b0;
    logic [28:0] DISPADDR = '0;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY;
    logic [63:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RLAST = 1'b0;
    logic        RREADY;
    logic        FIFO_WR;
    logic [63:0] FIFO_WDATA;
    logic        FIFO_AFULL = 1'b0;
`ifdef DISP_FRAME_END_EN
    logic        FRAME_END;
`endif

    disp_vramctrl #(.H_PIXELS(H), .V_LINES(V), .BURST_LEN(BL)) dut (
        .ACLK        (ACLK),
        .ARST        (ARST),
        .DSP_VSYNC_X (DSP_VSYNC_X),
        .DISPON      (DISPON),
        .DISPADDR    (DISPADDR),
        .ARADDR      (ARADDR),
        .ARLEN       (ARLEN),
        .ARSIZE      (ARSIZE),
        .ARBURST     (ARBURST),
        .ARVALID     (ARVALID),
        .ARREADY     (ARREADY),
        .RDATA       (RDATA),
        .RVALID      (RVALID),
        .RLAST       (RLAST),
        .RREADY      (RREADY),
        .FIFO_WR     (FIFO_WR),
        .FIFO_WDATA  (FIFO_WDATA),
`ifdef DISP_FRAME_END_EN
        .FRAME_END   (FRAME_END),
`endif
        .FIFO_AFULL  (FIFO_AFULL)
    );

    always #5 ACLK = ~ACLK;

    int tests = 0;
    int fails = 0;
    logic [63:0] exp_q[$];
    logic [31:0] ar_q[$];
    int ar_cnt = 0;
    int wr_cnt = 0;
    int fe_cnt = 0;
    bit ar_ok = 1'b1;
    bit slv_busy = 1'b0;
    logic [31:0] slv_addr = '0;
    int slv_beat = 0;

    assign ARREADY = ar_ok && !slv_busy;

    function automatic logic [63:0] mem(input logic [31:0] a);
        return {a ^ 32'hA5A5_0000, ~a};
    endfunction

    // AXI slave + FIFO/AR scoreboard; samples at the edge, updates 1 ns later
    always begin
        logic s_ar, s_r, s_last, s_wr, s_rst, s_fe;
        logic [63:0] s_wd, e;
        logic [31:0] s_addr, ea;
        @(posedge ACLK);
        s_ar = ARVALID && ARREADY;
        s_r = RVALID && RREADY;
        s_last = RLAST;
        s_wr = FIFO_WR;
        s_wd = FIFO_WDATA;
        s_addr = ARADDR;
        s_rst = ARST;
        s_fe = 1'b0;
`ifdef DISP_FRAME_END_EN
        s_fe = FRAME_END;
`endif
        #1;
        if (s_rst) begin
            slv_busy = 1'b0;
            exp_q.delete();
            ar_q.delete();
        end else begin
            if (s_wr) begin
                wr_cnt++;
                tests++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL fifo_wr_unexpected got=%h", s_wd);
                end else begin
                    e = exp_q.pop_front();
                    if (s_wd !== e) begin
                        fails++;
                        $display("FAIL fifo_wdata got=%h exp=%h", s_wd, e);
                    end
                end
            end
            if (s_r) begin
                exp_q.push_back(mem(slv_addr + 32'(slv_beat) * 32'd8));
                slv_beat++;
                if (s_last) slv_busy = 1'b0;
            end
            if (s_ar) begin
                ar_cnt++;
                tests++;
                if (ar_q.size() == 0) begin
                    fails++;
                    $display("FAIL ar_unexpected got=%h", s_addr);
                end else begin
                    ea = ar_q.pop_front();
                    if (s_addr !== ea) begin
                        fails++;
                        $display("FAIL araddr got=%h exp=%h", s_addr, ea);
                    end
                end
                slv_busy = 1'b1;
                slv_addr = s_addr;
                slv_beat = 0;
            end
            if (s_fe) fe_cnt++;
        end
        RVALID = slv_busy && ($urandom_range(0, 3) != 0);
        RLAST = slv_busy && (slv_beat == BL - 1);
        RDATA = RVALID ? mem(slv_addr + 32'(slv_beat) * 32'd8) : 64'h0;
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge ACLK);
            #2;
        end
    endtask

    task automatic vsync();
        DSP_VSYNC_X = 1'b0;
        tick(4);
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic push_frame(input logic [28:0] base, input int n);
        logic [31:0] b;
        b = {3'b000, base} & 32'hFFFF_FF80;
        for (int i = 0; i < n; i++) ar_q.push_back(b + 32'(i) * 32'd128);
    endtask

    task automatic wait_ar(input int n, input string name);
        int i;
        for (i = 0; i < 3000; i++) begin
            if (ar_cnt >= n) break;
            tick(1);
        end
        if (i == 3000) begin
            tests++;
            fails++;
            $display("FAIL %s_ar_timeout got=%0d exp=%0d", name, ar_cnt, n);
        end
    endtask

    task automatic wait_done(input string name);
        int i;
        for (i = 0; i < 5000; i++) begin
            if (ar_q.size() == 0 && !slv_busy && exp_q.size() == 0 &&
                !RREADY && !ARVALID && !FIFO_WR) break;
            tick(1);
        end
        tests++;
        if (i == 5000) begin
            fails++;
            $display("FAIL %s_done_timeout ar_left=%0d", name, ar_q.size());
        end
    endtask

    task automatic test_reset();
        ARST = 1'b1;
        tick(3);
        tests += 5;
        if (ARVALID !== 1'b0) begin fails++; $display("FAIL rst_arvalid got=%b exp=0", ARVALID); end
        if (RREADY !== 1'b0) begin fails++; $display("FAIL rst_rready got=%b exp=0", RREADY); end
        if (FIFO_WR !== 1'b0) begin fails++; $display("FAIL rst_fifo_wr got=%b exp=0", FIFO_WR); end
        if (ARADDR !== 32'h0) begin fails++; $display("FAIL rst_araddr got=%h exp=0", ARADDR); end
        if (FIFO_WDATA !== 64'h0) begin fails++; $display("FAIL rst_wdata got=%h exp=0", FIFO_WDATA); end
        tests += 3;
        if (ARLEN !== 8'(BL - 1)) begin fails++; $display("FAIL arlen got=%h exp=%h", ARLEN, BL - 1); end
        if (ARSIZE !== 3'b011) begin fails++; $display("FAIL arsize got=%b exp=011", ARSIZE); end
        if (ARBURST !== 2'b01) begin fails++; $display("FAIL arburst got=%b exp=01", ARBURST); end
`ifdef DISP_FRAME_END_EN
        tests++;
        if (FRAME_END !== 1'b0) begin fails++; $display("FAIL rst_frame_end got=%b exp=0", FRAME_END); end
`endif
        ARST = 1'b0;
        tick(2);
    endtask

    task automatic test_full_frame();
        int fe0;
        DISPON = 1'b1;
        DISPADDR = 29'h0100_0000;
        ar_cnt = 0;
        wr_cnt = 0;
        fe0 = fe_cnt;
        push_frame(DISPADDR, NB);
        vsync();
        wait_done("full");
        tests += 2;
        if (ar_cnt != NB) begin fails++; $display("FAIL full_bursts got=%0d exp=%0d", ar_cnt, NB); end
        if (wr_cnt != BEATS) begin fails++; $display("FAIL full_beats got=%0d exp=%0d", wr_cnt, BEATS); end
`ifdef DISP_FRAME_END_EN
        tests++;
        if (fe_cnt != fe0 + 1) begin fails++; $display("FAIL full_frame_end got=%0d exp=%0d", fe_cnt - fe0, 1); end
`endif
    endtask

    task automatic test_dispoff();
        int seen;
        DISPON = 1'b0;
        ar_cnt = 0;
        wr_cnt = 0;
        seen = 0;
        vsync();
        repeat (40) begin
            tick(1);
            if (ARVALID) seen++;
        end
        tests += 2;
        if (seen != 0) begin fails++; $display("FAIL off_arvalid got=%0d exp=0", seen); end
        if (wr_cnt != 0) begin fails++; $display("FAIL off_fifo_wr got=%0d exp=0", wr_cnt); end
    endtask

    task automatic test_afull();
        int bad;
        logic [31:0] held;
        DISPON = 1'b1;
        DISPADDR = 29'h0040_0000;
        ar_cnt = 0;
        wr_cnt = 0;
        push_frame(DISPADDR, NB);
        vsync();
        wait_ar(2, "afull");
        FIFO_AFULL = 1'b1;
        bad = 0;
        repeat (50) begin
            tick(1);
            if (ARVALID) bad++;
        end
        tests += 2;
        if (bad != 0) begin fails++; $display("FAIL afull_hold got=%0d exp=0", bad); end
        if (ar_cnt != 2) begin fails++; $display("FAIL afull_ar_count got=%0d exp=2", ar_cnt); end
        ar_ok = 1'b0;
        FIFO_AFULL = 1'b0;
        tick(1);
        tests++;
        if (ARVALID !== 1'b1) begin fails++; $display("FAIL afull_release got=%b exp=1", ARVALID); end
        FIFO_AFULL = 1'b1;
        held = ARADDR;
        bad = 0;
        repeat (5) begin
            tick(1);
            if (ARVALID !== 1'b1 || ARADDR !== held) bad++;
        end
        tests++;
        if (bad != 0) begin fails++; $display("FAIL arvalid_sticky got=%0d exp=0", bad); end
        FIFO_AFULL = 1'b0;
        ar_ok = 1'b1;
        wait_done("afull");
        tests++;
        if (wr_cnt != BEATS) begin fails++; $display("FAIL afull_beats got=%0d exp=%0d", wr_cnt, BEATS); end
    endtask

    task automatic test_abort();
        int fe0;
        DISPON = 1'b1;
        DISPADDR = 29'h0080_0000;
        ar_cnt = 0;
        wr_cnt = 0;
        fe0 = fe_cnt;
        push_frame(DISPADDR, 5);
        vsync();
        wait_ar(5, "abort");
        DISPON = 1'b0;
        wait_done("abort");
        tick(30);
        tests += 2;
        if (wr_cnt != 5 * BL) begin fails++; $display("FAIL abort_beats got=%0d exp=%0d", wr_cnt, 5 * BL); end
        if (ar_cnt != 5) begin fails++; $display("FAIL abort_bursts got=%0d exp=5", ar_cnt); end
`ifdef DISP_FRAME_END_EN
        tests++;
        if (fe_cnt != fe0) begin fails++; $display("FAIL abort_frame_end got=%0d exp=0", fe_cnt - fe0); end
`endif
    endtask

    task automatic test_align_vsync();
        DISPON = 1'b1;
        DISPADDR = 29'h0000_0055;
        ar_cnt = 0;
        wr_cnt = 0;
        push_frame(29'h0, NB);
        vsync();
        wait_ar(3, "align");
        DISPADDR = 29'h1FFF_FF80;
        vsync();
        wait_done("align");
        tick(40);
        tests += 2;
        if (ar_cnt != NB) begin fails++; $display("FAIL align_bursts got=%0d exp=%0d", ar_cnt, NB); end
        if (wr_cnt != BEATS) begin fails++; $display("FAIL align_beats got=%0d exp=%0d", wr_cnt, BEATS); end
    endtask

    task automatic test_reset_mid();
        int i;
        DISPON = 1'b1;
        DISPADDR = 29'h0200_0000;
        ar_cnt = 0;
        wr_cnt = 0;
        push_frame(DISPADDR, NB);
        vsync();
        wait_ar(2, "rstmid");
        for (i = 0; i < 100; i++) begin
            if (RVALID && RREADY) break;
            tick(1);
        end
        ARST = 1'b1;
        tick(1);
        tests += 3;
        if (RREADY !== 1'b0) begin fails++; $display("FAIL rstmid_rready got=%b exp=0", RREADY); end
        if (FIFO_WR !== 1'b0) begin fails++; $display("FAIL rstmid_fifo_wr got=%b exp=0", FIFO_WR); end
        if (ARVALID !== 1'b0) begin fails++; $display("FAIL rstmid_arvalid got=%b exp=0", ARVALID); end
        ARST = 1'b0;
        tick(2);
        ar_cnt = 0;
        wr_cnt = 0;
        push_frame(DISPADDR, NB);
        vsync();
        wait_done("rstmid");
        tests += 2;
        if (ar_cnt != NB) begin fails++; $display("FAIL rstmid_bursts got=%0d exp=%0d", ar_cnt, NB); end
        if (wr_cnt != BEATS) begin fails++; $display("FAIL rstmid_beats got=%0d exp=%0d", wr_cnt, BEATS); end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_dispoff();
        test_afull();
        test_abort();
        test_align_vsync();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired tests=%0d", tests);
        $fatal(1, "watchdog");
    end
endmodule
